// File: rtl/cordic_ica_pkg.sv
// cordic_ica_pkg: shared default widths and rot_feeder FSM state encoding
package cordic_ica_pkg;
    localparam int DATA_WIDTH    = 16;
    localparam int CORDIC_STAGES = 16;
    localparam int LEN_WIDTH     = 11;
    typedef logic [2:0] state_t;
    localparam state_t IDLE  = 3'd0;
    localparam state_t ARMED = 3'd1;
    localparam state_t RUN   = 3'd2;
    localparam state_t DRAIN = 3'd3;
    localparam state_t DONE  = 3'd4;
endpackage

// File: rtl/feed_fifo.sv
// feed_fifo: synchronous FIFO with full/empty flags; a push into a full FIFO is taken when a pop frees a slot
module feed_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] cnt;
    logic do_push, do_pop;
    assign full    = cnt[AW];
    assign empty   = cnt == '0;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];
    // storage written only on accepted pushes
    always_ff @(posedge clk)
        if (do_push) mem[wr_ptr] <= din;
    // read/write pointers and occupancy
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
endmodule

// File: rtl/rot_feeder.sv
// rot_feeder: batches buffered samples into the CORDIC rotation pipeline; ROT_FEEDER_STATS_EN adds per-batch stats
module rot_feeder #(
    parameter int DATA_WIDTH    = cordic_ica_pkg::DATA_WIDTH,
    parameter int CORDIC_STAGES = cordic_ica_pkg::CORDIC_STAGES,
    parameter int LEN_WIDTH     = cordic_ica_pkg::LEN_WIDTH,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     load_i,
    input  logic [CORDIC_STAGES-1:0] dir_i,
    input  logic [1:0]               quad_i,
    input  logic                     start_i,
    input  logic [LEN_WIDTH-1:0]     batch_len_i,
    input  logic                     s_valid_i,
    output logic                     s_ready_o,
    input  logic [DATA_WIDTH-1:0]    s_x_i,
    input  logic [DATA_WIDTH-1:0]    s_y_i,
    output logic                     rot_enable_o,
    output logic [DATA_WIDTH-1:0]    rot_x_o,
    output logic [DATA_WIDTH-1:0]    rot_y_o,
    output logic [CORDIC_STAGES-1:0] rot_dir_o,
    output logic [1:0]               rot_quad_o,
    output logic                     rot_dir_vld_o,
    output logic                     rot_angle_n_o,
    input  logic                     rot_valid_i,
    input  logic [DATA_WIDTH-1:0]    rot_x_i,
    input  logic [DATA_WIDTH-1:0]    rot_y_i,
    output logic                     m_valid_o,
    output logic [DATA_WIDTH-1:0]    m_x_o,
    output logic [DATA_WIDTH-1:0]    m_y_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     err_o
`ifdef ROT_FEEDER_STATS_EN
    ,
    output logic [LEN_WIDTH:0]       stat_issued_o,
    output logic [31:0]              stat_cycles_o
`endif
);
    import cordic_ica_pkg::*;
    state_t state;
    logic [CORDIC_STAGES-1:0] dir_q;
    logic [1:0] quad_q;
    logic [LEN_WIDTH:0] remaining, outstanding;
    logic rdy_en, fifo_full, fifo_empty, issue, ret, spurious;
    logic [2*DATA_WIDTH-1:0] fifo_dout;
    assign s_ready_o     = rdy_en && !fifo_full;
    assign issue         = state == RUN && !fifo_empty && remaining != '0;
    assign ret           = rot_valid_i && outstanding != '0;
    assign spurious      = rot_valid_i && outstanding == '0;
    assign rot_dir_o     = dir_q;
    assign rot_quad_o    = quad_q;
    assign rot_dir_vld_o = state != IDLE;
    assign rot_angle_n_o = 1'b0;
    assign busy_o        = state == RUN || state == DRAIN;
    assign done_o        = state == DONE;
    feed_fifo #(.WIDTH(2*DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (s_valid_i && s_ready_o),
        .pop   (issue),
        .din   ({s_x_i, s_y_i}),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );
    // batch FSM, direction holding registers, remaining count and sticky error
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state     <= IDLE;
            dir_q     <= '0;
            quad_q    <= '0;
            remaining <= '0;
            rdy_en    <= 1'b0;
            err_o     <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
            if (spurious || (state == IDLE && start_i) || (busy_o && load_i)) err_o <= 1'b1;
            if ((state == IDLE || state == ARMED) && load_i) begin
                dir_q  <= dir_i;
                quad_q <= quad_i;
            end
            if (issue) remaining <= remaining - (LEN_WIDTH+1)'(1);
            case (state)
                IDLE:  if (load_i) state <= ARMED;
                ARMED: if (start_i) begin
                    state     <= RUN;
                    remaining <= {batch_len_i == '0, batch_len_i};
                end
                RUN:   if (remaining == '0) state <= DRAIN;
                DRAIN: if (outstanding == '0) state <= DONE;
                default: state <= ARMED;
            endcase
        end
    // samples in flight inside the rotation pipeline
    always_ff @(posedge clk or posedge reset)
        if (reset) outstanding <= '0;
        else if (state == ARMED && start_i) outstanding <= '0;
        else outstanding <= outstanding + (LEN_WIDTH+1)'(issue) - (LEN_WIDTH+1)'(ret);
    // issue register toward the pipeline and one-cycle result forwarding
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            rot_enable_o <= 1'b0;
            rot_x_o      <= '0;
            rot_y_o      <= '0;
            m_valid_o    <= 1'b0;
            m_x_o        <= '0;
            m_y_o        <= '0;
        end else begin
            rot_enable_o <= issue;
            if (issue) {rot_x_o, rot_y_o} <= fifo_dout;
            m_valid_o <= rot_valid_i;
            m_x_o     <= rot_x_i;
            m_y_o     <= rot_y_i;
        end
`ifdef ROT_FEEDER_STATS_EN
    logic [LEN_WIDTH:0] issued;
    logic [31:0] cycles;
    // per-batch tallies, published when the batch completes
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            issued        <= '0;
            cycles        <= '0;
            stat_issued_o <= '0;
            stat_cycles_o <= '0;
        end else begin
            if (state == ARMED && start_i) begin
                issued <= '0;
                cycles <= '0;
            end else begin
                if (issue) issued <= issued + (LEN_WIDTH+1)'(1);
                if (busy_o) cycles <= cycles + 32'd1;
            end
            if (done_o) begin
                stat_issued_o <= issued;
                stat_cycles_o <= cycles + 32'd1;
            end
        end
`endif
endmodule
